// File: rtl/ac_axis_tx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ac_axis_tx_ctrl
// Description : Drains the wide output buffer onto an AXI-Stream master with
//               frame (tuser) / row (tlast) framing and partial-beat tkeep.
// Revision    : 1.0 - initial release
// ============================================================================
module ac_axis_tx_ctrl #(
    parameter int UPSP_WRTDATA_WIDTH = 24,
    parameter int DST_IMG_WIDTH      = 4096,
    parameter int DST_IMG_HEIGHT     = 2160,
    parameter int N_PARALLEL         = 2
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            start_i,
    input  logic                                            abort_i,
    input  logic                                            buf_empty_i,
    input  logic [UPSP_WRTDATA_WIDTH*N_PARALLEL-1:0]        buf_rdata_i,
    output logic                                            buf_rd_o,
    output logic                                            m_axis_tvalid_o,
    input  logic                                            m_axis_tready_i,
    output logic [UPSP_WRTDATA_WIDTH*N_PARALLEL-1:0]        m_axis_tdata_o,
    output logic [UPSP_WRTDATA_WIDTH*N_PARALLEL/8-1:0]      m_axis_tkeep_o,
    output logic                                            m_axis_tlast_o,
    output logic                                            m_axis_tuser_o,
    output logic                                            busy_o,
    output logic                                            frame_done_o
);

    localparam int c_TW         = UPSP_WRTDATA_WIDTH * N_PARALLEL;
    localparam int c_KW         = c_TW / 8;
    localparam int c_N_UPSP_WRT = UPSP_WRTDATA_WIDTH / 24;
    localparam int c_N_ROW_PKG  = DST_IMG_WIDTH / c_N_UPSP_WRT;
    localparam int c_BEATS      = (c_N_ROW_PKG + N_PARALLEL - 1) / N_PARALLEL;
    localparam int c_V_LAST     = c_N_ROW_PKG - (c_BEATS - 1) * N_PARALLEL;
    localparam int c_COL_W      = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_ROW_W      = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
    localparam int c_KEEP_SHIFT = (N_PARALLEL - c_V_LAST) * UPSP_WRTDATA_WIDTH / 8;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(c_BEATS - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(DST_IMG_HEIGHT - 1);
    localparam logic [c_KW-1:0]    c_KEEP_ALL = '1;
    // Word 0 sits in the top slice, so a short last beat keeps the upper bytes.
    localparam logic [c_KW-1:0]    c_KEEP_LAST = c_KEEP_ALL << c_KEEP_SHIFT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q,  state_d;
    logic [c_COL_W-1:0]  col_q,    col_d;
    logic [c_ROW_W-1:0]  row_q,    row_d;
    logic                tvalid_q, tvalid_d;
    logic [c_TW-1:0]     tdata_q,  tdata_d;
    logic [c_KW-1:0]     tkeep_q,  tkeep_d;
    logic                tlast_q,  tlast_d;
    logic                tuser_q,  tuser_d;

    logic                w_hs;
    logic                w_load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
        end
    end

    always_comb begin
        w_hs     = tvalid_q & m_axis_tready_i;
        w_load   = (state_q == ST_RUN) & ~buf_empty_i & (~tvalid_q | m_axis_tready_i);

        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        tvalid_d = tvalid_q & ~w_hs;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;

        if (w_load) begin
            tvalid_d = 1'b1;
            tdata_d  = buf_rdata_i;
            tuser_d  = (row_q == '0) && (col_q == '0);
            tlast_d  = (col_q == c_COL_LAST);
            tkeep_d  = (col_q == c_COL_LAST) ? c_KEEP_LAST : c_KEEP_ALL;
            if (col_q == c_COL_LAST) begin
                col_d = '0;
                row_d = (row_q == c_ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_RUN: begin
                if (abort_i || (w_load && (col_q == c_COL_LAST) && (row_q == c_ROW_LAST))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!tvalid_q || m_axis_tready_i) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign buf_rd_o        = w_load;
    assign m_axis_tvalid_o = tvalid_q;
    assign m_axis_tdata_o  = tdata_q;
    assign m_axis_tkeep_o  = tkeep_q;
    assign m_axis_tlast_o  = tlast_q;
    assign m_axis_tuser_o  = tuser_q;
    assign busy_o          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign frame_done_o    = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ac_axis_tx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ac_axis_tx_ctrl
// Description : Self-checking bench; two configurations (8x2/NP2, 6x1/NP4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ac_axis_tx_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_start, a_abort, a_empty, a_ready;
    logic [47:0] a_rdata;
    logic        a_rd, a_valid, a_last, a_user, a_busy, a_done;
    logic [47:0] a_data;
    logic [5:0]  a_keep;

    logic        b_start, b_abort, b_empty, b_ready;
    logic [95:0] b_rdata;
    logic        b_rd, b_valid, b_last, b_user, b_busy, b_done;
    logic [95:0] b_data;
    logic [11:0] b_keep;

    ac_axis_tx_ctrl #(
        .UPSP_WRTDATA_WIDTH(24), .DST_IMG_WIDTH(8), .DST_IMG_HEIGHT(2), .N_PARALLEL(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(a_start), .abort_i(a_abort),
        .buf_empty_i(a_empty), .buf_rdata_i(a_rdata), .buf_rd_o(a_rd),
        .m_axis_tvalid_o(a_valid), .m_axis_tready_i(a_ready), .m_axis_tdata_o(a_data),
        .m_axis_tkeep_o(a_keep), .m_axis_tlast_o(a_last), .m_axis_tuser_o(a_user),
        .busy_o(a_busy), .frame_done_o(a_done)
    );

    ac_axis_tx_ctrl #(
        .UPSP_WRTDATA_WIDTH(24), .DST_IMG_WIDTH(6), .DST_IMG_HEIGHT(1), .N_PARALLEL(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(b_start), .abort_i(b_abort),
        .buf_empty_i(b_empty), .buf_rdata_i(b_rdata), .buf_rd_o(b_rd),
        .m_axis_tvalid_o(b_valid), .m_axis_tready_i(b_ready), .m_axis_tdata_o(b_data),
        .m_axis_tkeep_o(b_keep), .m_axis_tlast_o(b_last), .m_axis_tuser_o(b_user),
        .busy_o(b_busy), .frame_done_o(b_done)
    );

    int tests = 0;
    int fails = 0;

    logic [47:0] a_exp_q[$];
    logic [95:0] b_exp_q[$];
    int   beat_k, fd_cnt, cyc_n, first_hs, last_hs, done_cyc;
    int   b_bk, b_fd;
    logic prev_stall;
    logic [55:0] saved;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected byte enables from row geometry: a beat carrying v words enables its top v slices.
    function automatic logic [11:0] exp_keep(input int col, input int w, input int np);
        int beats, v;
        logic [11:0] k;
        beats = (w + np - 1) / np;
        v     = (col == beats - 1) ? w - (beats - 1) * np : np;
        k     = '0;
        for (int b = (np - v) * 3; b < np * 3; b++) k[b] = 1'b1;
        return k;
    endfunction

    task automatic cyc();
        logic        a_pop, b_pop;
        logic [11:0] k;
        #1;
        if (prev_stall && rst_n) begin
            chk("hold_valid", a_valid, 1'b1);
            chk("hold_fields", {a_data, a_keep, a_last, a_user}, saved);
        end
        a_pop = a_rd;
        if (a_rd) begin
            chk("rd_gated", !a_valid || a_ready, 1'b1);
            a_exp_q.push_back(a_rdata);
        end
        if (a_valid && a_ready && rst_n) begin
            if (a_exp_q.size() == 0) chk("unexpected_beat", 1'b1, 1'b0);
            else chk("tdata", a_data, a_exp_q.pop_front());
            chk("tuser", a_user, beat_k == 0);
            chk("tlast", a_last, (beat_k % 4) == 3);
            k = exp_keep(beat_k % 4, 8, 2);
            chk("tkeep", a_keep, k[5:0]);
            if (beat_k == 0) first_hs = cyc_n;
            last_hs = cyc_n;
            beat_k++;
        end
        if (a_done) begin
            fd_cnt++;
            done_cyc = cyc_n;
            chk("busy_in_done", a_busy, 1'b0);
        end
        prev_stall = a_valid && !a_ready;
        saved      = {a_data, a_keep, a_last, a_user};

        b_pop = b_rd;
        if (b_rd) b_exp_q.push_back(b_rdata);
        if (b_valid && b_ready && rst_n) begin
            if (b_exp_q.size() == 0) chk("b_unexpected_beat", 1'b1, 1'b0);
            else chk("b_tdata", b_data, b_exp_q.pop_front());
            chk("b_tuser", b_user, b_bk == 0);
            chk("b_tlast", b_last, (b_bk % 2) == 1);
            chk("b_tkeep", b_keep, exp_keep(b_bk % 2, 6, 4));
            b_bk++;
        end
        if (b_done) b_fd++;

        @(posedge clk);
        #1;
        cyc_n++;
        if (a_pop) a_rdata = 48'({$urandom, $urandom});
        if (b_pop) b_rdata = {$urandom, $urandom, $urandom};
    endtask

    task automatic go();
        a_start = 1'b1;
        beat_k  = 0;
        cyc();
        a_start = 1'b0;
        chk("busy_after_start", a_busy, 1'b1);
    endtask

    task automatic wait_frame(input int max);
        int n  = 0;
        int f0 = fd_cnt;
        while (fd_cnt == f0 && n < max) begin
            cyc();
            n++;
        end
        chk("frame_timeout", fd_cnt - f0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n   = 1'b0;
        a_start = 1'b0; a_abort = 1'b0; a_empty = 1'b1; a_ready = 1'b0;
        b_start = 1'b0; b_abort = 1'b0; b_empty = 1'b1; b_ready = 1'b0;
        a_rdata = 48'({$urandom, $urandom});
        b_rdata = {$urandom, $urandom, $urandom};
        beat_k = 0; fd_cnt = 0; cyc_n = 0; first_hs = 0; last_hs = 0; done_cyc = 0;
        b_bk = 0; b_fd = 0; prev_stall = 1'b0; saved = '0;
        @(posedge clk); #1;

        cyc(); cyc();
        chk("reset_outputs", {a_valid, a_data, a_keep, a_last, a_user, a_rd, a_busy, a_done}, '0);
        rst_n = 1'b1;

        a_abort = 1'b1; cyc(); a_abort = 1'b0; cyc();
        chk("abort_idle_busy", a_busy, 1'b0);

        // Full buffer, no backpressure, start held high through the whole frame and DONE.
        a_empty = 1'b0; a_ready = 1'b1; a_start = 1'b1; beat_k = 0;
        cyc();
        chk("t1_busy", a_busy, 1'b1);
        n = 0;
        while (fd_cnt == 0 && n < 100) begin cyc(); n++; end
        a_start = 1'b0;
        repeat (10) cyc();
        chk("t1_frames", fd_cnt, 1);
        chk("t1_beats", beat_k, 8);
        chk("t1_consecutive", last_hs - first_hs, 7);
        chk("t1_done_lat", (done_cyc - last_hs) <= 2, 1'b1);
        chk("t1_idle_busy", a_busy, 1'b0);
        chk("t1_idle_valid", a_valid, 1'b0);

        // Toggling ready, random starvation.
        go();
        n = 0;
        while (fd_cnt == 1 && n < 300) begin
            a_ready = ~a_ready;
            a_empty = ($urandom_range(0, 2) == 0);
            cyc();
            n++;
        end
        chk("t2_frames", fd_cnt, 2);
        chk("t2_beats", beat_k, 8);
        chk("t2_queue_empty", a_exp_q.size(), 0);

        // Abort with beat 2 stalled in the output register.
        a_empty = 1'b0; a_ready = 1'b1;
        go();
        n = 0;
        while (beat_k < 2 && n < 50) begin cyc(); n++; end
        a_ready = 1'b0; a_abort = 1'b1;
        cyc();
        a_abort = 1'b0;
        repeat (3) begin
            cyc();
            chk("abort_no_rd", a_rd, 1'b0);
        end
        chk("abort_held_valid", a_valid, 1'b1);
        chk("abort_busy", a_busy, 1'b1);
        a_ready = 1'b1;
        wait_frame(20);
        chk("abort_beats", beat_k, 3);
        chk("abort_queue_empty", a_exp_q.size(), 0);
        cyc();
        chk("abort_idle", a_busy, 1'b0);
        go();
        wait_frame(50);
        chk("restart_beats", beat_k, 8);

        // Reset mid-row with a stalled beat.
        go();
        n = 0;
        while (beat_k < 3 && n < 50) begin cyc(); n++; end
        a_ready = 1'b0;
        cyc();
        chk("pre_reset_valid", a_valid, 1'b1);
        rst_n = 1'b0; a_start = 1'b1;
        cyc();
        chk("midreset_outputs", {a_valid, a_data, a_keep, a_last, a_user, a_rd, a_busy, a_done}, '0);
        cyc();
        chk("reset_start_ignored", a_busy, 1'b0);
        rst_n = 1'b1; a_start = 1'b0;
        cyc();
        chk("post_reset_idle", a_busy, 1'b0);
        a_exp_q.delete();
        a_ready = 1'b1;
        go();
        wait_frame(50);
        chk("post_reset_beats", beat_k, 8);

        // Partial last beat: 6 words over 4-wide beats.
        b_empty = 1'b0; b_ready = 1'b1; b_start = 1'b1;
        cyc();
        b_start = 1'b0;
        n = 0;
        while (b_fd == 0 && n < 30) begin cyc(); n++; end
        chk("b_frames", b_fd, 1);
        chk("b_beats", b_bk, 2);
        chk("b_idle", b_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
